// File: rtl/master_bus_arbiter.sv
// Two-master bus arbiter for the shared memory bus.
// Master A is instruction fetch and master B is data load/store.
// The owner keeps the bus for a whole transaction. When both masters
// request, ownership alternates round-robin. A watchdog takes the bus
// back from an owner that holds it too long without completing.
// All outputs come from registers or from a decode of the state register,
// so there is no combinational path from a request to a grant.
module master_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8,
    parameter bit A_FIRST        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reqA,
    input  logic reqB,
    input  logic busDone,
    output logic useA,
    output logic grantA,
    output logic grantB,
    output logic busy,
    output logic timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // The watchdog fires when the count reaches TIMEOUT_CYCLES-1.
    // The owner therefore holds the bus for exactly TIMEOUT_CYCLES cycles.
    localparam bit              WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam int              LIMIT_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(LIMIT_INT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            stateReg, stateNext;
    logic              lastAReg, lastANext;
    logic              useAReg, useANext;
    logic              timeoutReg, timeoutNext;
    logic [CNT_W-1:0]  countReg, countNext;
    logic              winnerA;
    logic [1:0]        grantVec;

    // Round-robin pick.
    // A wins when it is the only requester, or when both request and B owned last.
    assign winnerA = reqA & (~reqB | ~lastAReg);

    // State register plus the registered side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            lastAReg   <= ~A_FIRST;
            useAReg    <= 1'b1;
            timeoutReg <= 1'b0;
            countReg   <= '0;
        end else begin
            stateReg   <= stateNext;
            lastAReg   <= lastANext;
            useAReg    <= useANext;
            timeoutReg <= timeoutNext;
            countReg   <= countNext;
        end
    end

    // Next-state logic, round-robin history, watchdog counter and mux-select hold.
    always_comb begin
        stateNext   = stateReg;
        lastANext   = lastAReg;
        useANext    = useAReg;
        timeoutNext = 1'b0;
        countNext   = '0;

        case (stateReg)
            IDLE: begin
                // busDone is ignored while nobody owns the bus.
                if (reqA | reqB) begin
                    stateNext = winnerA ? OWN_A : OWN_B;
                end
            end
            OWN_A: begin
                if (busDone) begin
                    // A completed transaction beats a watchdog expiry in the same cycle.
                    if (reqB) begin
                        stateNext = OWN_B;
                    end else if (reqA) begin
                        stateNext = OWN_A;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (!reqA) begin
                    stateNext = IDLE;
                end else if (WDOG_EN && countReg == LIMIT) begin
                    stateNext   = IDLE;
                    timeoutNext = 1'b1;
                end else begin
                    countNext = (countReg == CNT_MAX) ? countReg : countReg + 1'b1;
                end
            end
            OWN_B: begin
                if (busDone) begin
                    if (reqA) begin
                        stateNext = OWN_A;
                    end else if (reqB) begin
                        stateNext = OWN_B;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (!reqB) begin
                    stateNext = IDLE;
                end else if (WDOG_EN && countReg == LIMIT) begin
                    stateNext   = IDLE;
                    timeoutNext = 1'b1;
                end else begin
                    countNext = (countReg == CNT_MAX) ? countReg : countReg + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Remember the new owner. In IDLE the mux select keeps its last value,
        // so the select line does not toggle while nobody owns the bus.
        if (stateNext == OWN_A) begin
            lastANext = 1'b1;
            useANext  = 1'b1;
        end else if (stateNext == OWN_B) begin
            lastANext = 1'b0;
            useANext  = 1'b0;
        end
    end

    // Per-master grant decode from the state register.
    // Only one state is active at a time, so the two grants can never both be high.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_grant
            assign grantVec[gi] = (stateReg == ((gi == 0) ? OWN_A : OWN_B));
        end
    endgenerate

    assign grantA  = grantVec[0];
    assign grantB  = grantVec[1];
    assign busy    = |grantVec;
    assign useA    = useAReg;
    assign timeout = timeoutReg;

endmodule

// File: tb/tb_master_bus_arbiter.sv
// Directed testbench for master_bus_arbiter.
// The DUT is built with TIMEOUT_CYCLES=4 and A_FIRST=1.
// Expected values are packed as {grantA, grantB, useA, busy, timeout}.
module tb_master_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic reqA = 1'b0;
    logic reqB = 1'b0;
    logic busDone = 1'b0;
    logic useA, grantA, grantB, busy, timeout;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       rstN;
        logic       a;
        logic       b;
        logic       done;
        logic [4:0] exp;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    master_bus_arbiter #(
        .TIMEOUT_CYCLES(4),
        .CNT_W(8),
        .A_FIRST(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reqA(reqA),
        .reqB(reqB),
        .busDone(busDone),
        .useA(useA),
        .grantA(grantA),
        .grantB(grantB),
        .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then compare 1 ns after the rising edge.
    task automatic apply(input string name, input logic r, input logic a, input logic b,
                         input logic d, input logic [4:0] exp);
        logic [4:0] act;
        @(negedge clk);
        rst_n   = r;
        reqA    = a;
        reqB    = b;
        busDone = d;
        @(posedge clk);
        #1;
        act = {grantA, grantB, useA, busy, timeout};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got {gA,gB,useA,busy,to}=%b expected %b", name, act, exp);
        end else begin
            $display("ok   %s rst_n=%b reqA=%b reqB=%b busDone=%b -> %b", name, r, a, b, d, act);
        end
    endtask

    initial begin
        // rstN, reqA, reqB, busDone, expected {gA,gB,useA,busy,to}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00100}; // reset state
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10110}; // A alone is granted
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10110};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00100}; // done, nobody -> IDLE, useA holds
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00100}; // busDone in IDLE is ignored
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010}; // B alone is granted
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b01010}; // done, B again: count restarts
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b01010};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00000}; // IDLE, useA holds 0
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b00100}; // reset: useA back to 1
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10110}; // contention: A wins first
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10110};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10110};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01010}; // handover to B, no idle cycle
        vecs[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01010};
        vecs[23] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01010};
        vecs[24] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b10110}; // handover to A
        vecs[25] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10110};
        vecs[26] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10110};
        vecs[27] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01010}; // handover to B
        vecs[28] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00000};
        vecs[29] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10110}; // A alone after B owned
        vecs[30] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b00100}; // owner abort -> IDLE, no timeout
        vecs[31] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
        vecs[32] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000}; // owner abort

        for (int i = 0; i < NVEC; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].rstN, vecs[i].a, vecs[i].b,
                  vecs[i].done, vecs[i].exp);
        end

        // Watchdog: A holds the bus for exactly 4 cycles. The next cycle is IDLE
        // with a timeout pulse, and on the edge after that the pending B wins.
        apply("wdog_grant1", 1'b1, 1'b1, 1'b0, 1'b0, 5'b10110);
        for (int i = 2; i <= 4; i++) begin
            apply($sformatf("wdog_grant%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 5'b10110);
        end
        apply("wdog_pulse", 1'b1, 1'b1, 1'b1, 1'b0, 5'b00101);
        apply("wdog_b_wins", 1'b1, 1'b1, 1'b1, 1'b0, 5'b01010);

        // busDone on the 4th owned cycle beats the watchdog: normal handover, no pulse.
        for (int i = 1; i <= 3; i++) begin
            apply($sformatf("race_hold%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 5'b01010);
        end
        apply("race_done_wins", 1'b1, 1'b1, 1'b1, 1'b1, 5'b10110);

        // Reset while B owns the bus drops the grant without a timeout pulse.
        // The next contention goes to A again.
        apply("rst_setup_b", 1'b1, 1'b1, 1'b1, 1'b1, 5'b01010);
        apply("rst_mid_b", 1'b0, 1'b1, 1'b1, 1'b0, 5'b00100);
        apply("rst_then_a", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
